mac_frame_sched: RTL and testbench
==================================

# mac_frame_sched

Frame scheduler placed directly upstream of the 8-lane byte-splitter (`mac_block`). It accepts arbitrary-length 64-bit AXI-Stream frames and normalises each one to exactly RS_CNT words: short frames are padded, long frames are truncated. It buffers the whole frame, then releases it as one gap-free burst, because the splitter restarts its write index whenever tvalid drops. It holds off the next frame until all 8 lane outputs have reported tlast.

## Interface
- RS_CNT, 236, words per normalised frame (instantiator sets 232 for the self_rs build)
- PAD_WORD, 64'h0, fill word written for each padded position
- DRAIN_TIMEOUT, 4096, max cycles in DRAIN before forced release
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- s_axis_input_tvalid / tready / tdata / tlast  in/out/in/in  1/1/64/1  upstream frame stream
- m_axis_output_tvalid / tready / tdata / tlast  out/in/out/out  1/1/64/1  to splitter input
- lane_tlast[8]  in  1 each  splitter per-lane output tlast pulses
- busy  out  1  high in any state other than FILL
- err_timeout  out  1  sticky: set when DRAIN times out; cleared only by reset
- frame_cnt, pad_cnt, trunc_cnt  out  16 each  statistics (see Configuration)

## Operation
- Reset: state=FILL; wr_cnt=rd_cnt=0; lane_done=0; s_tready=1; m_tvalid=m_tlast=0; m_tdata=0; busy=0; err_timeout=0; all counters=0.
- FILL: s_tready=1. Each accepted beat (s_tvalid&&s_tready) is written to buf[wr_cnt] and increments wr_cnt.
  - tlast beat with wr_cnt<RS_CNT-1 → PAD.
  - tlast beat with wr_cnt==RS_CNT-1 → READY.
  - non-tlast beat with wr_cnt==RS_CNT-1 → DROP.
  - A frame that is only a single tlast beat counts as 1 word.
- DROP: s_tready=1. Beats are discarded until a tlast beat is accepted → READY. trunc_cnt+1.
- PAD: s_tready=0. One PAD_WORD is written per cycle until position RS_CNT-1 has been written → READY. pad_cnt+1.
- READY: s_tready=0. Waits for m_tready=1 → SEND. m_tready is sampled only in READY.
- SEND: rd_cnt runs 0..RS_CNT-1, one read per cycle. The burst never stalls, and m_tready is ignored once the burst has started. → DRAIN after the last read issues.
- DRAIN: lane_done[j] is set on lane_tlast[j]. When all 8 bits are set: clear lane_done, wr_cnt=0, frame_cnt+1, → FILL. A lane_tlast that arrives during SEND is also captured.
- Timeout: the DRAIN cycle counter reaching DRAIN_TIMEOUT sets err_timeout and forces → FILL. lane_done is cleared on this exit as well.
- Counters are 16-bit and wrap from 0xFFFF to 0.

## Timing
- Buffer read latency is 1 cycle. The first m_tvalid beat is registered 1 cycle after SEND entry.
- m_tvalid stays high for exactly RS_CNT consecutive cycles. m_tlast is high only on beat RS_CNT-1.
- End of frame to burst start, when m_tready is already high:
  - for an exact-length frame, the transition to READY is 1 cycle after the tlast beat; SEND follows 1 cycle after that; m_tvalid rises on the next cycle.
  - for a padded frame, add (RS_CNT-1-last written index) cycles for PAD.
- s_tready drops on the cycle after the accepted beat that leaves FILL/DROP. No beat is accepted outside FILL/DROP.
- Reset mid-burst: on the next edge m_tvalid=0, m_tlast=0, and the buffer contents are abandoned.

## Configuration
- MAC_SCHED_STATS_EN defined: frame_cnt, pad_cnt and trunc_cnt are live registers.
- MAC_SCHED_STATS_EN undefined: those three outputs are tied to 0 and the counters are not built.
- err_timeout is present in both builds.

## Structure
- Shared package mac_sched_pkg holds:
  - the state enum (FILL, DROP, PAD, READY, SEND, DRAIN)
  - RS_CNT_SELF=232 and RS_CNT_STD=236
  - the lane count constant 8.
- Sub-module mac_frame_buf: RS_CNT×64 simple dual-port RAM, one write port, one registered read port, 1-cycle latency.

## Test plan
- 236-word frame, tlast on word 235, m_tready=1 → one 236-beat gap-free burst, data identical, tlast on beat 235; frame_cnt=1 after all lane_tlast arrive.
- 100-word frame → burst beats 0–99 carry the input data, beats 100–235 are 64'h0; pad_cnt=1.
- 300-word frame → first 236 words are sent, words 236–299 are consumed and dropped (s_tready=1 throughout); trunc_cnt=1; a following 10-word frame arrives padded and intact.
- m_tready=0 for 20 cycles in READY → m_tvalid stays 0; the burst starts 1 cycle after SEND entry; a later m_tready drop mid-burst does not stall it.
- lane_tlast[5] withheld with DRAIN_TIMEOUT=64 → err_timeout=1 after 64 DRAIN cycles, state returns to FILL, and the next frame is accepted.
- reset asserted at burst beat 50 → m_tvalid=0 next cycle; s_tready=1 and all counters 0 after reset.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared definitions for the MAC frame scheduler.
//   - sched_state_t : scheduler state encoding (FILL, DROP, PAD, READY, SEND, DRAIN)
//   - RS_CNT_SELF / RS_CNT_STD : words per normalised frame for the two builds
//   - LANE_CNT : number of splitter lanes whose tlast closes a frame
//   - DATA_W : stream data width
package mac_sched_pkg;

    localparam int RS_CNT_SELF = 232;
    localparam int RS_CNT_STD  = 236;
    localparam int LANE_CNT    = 8;
    localparam int DATA_W      = 64;

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        DROP  = 3'd1,
        PAD   = 3'd2,
        READY = 3'd3,
        SEND  = 3'd4,
        DRAIN = 3'd5
    } sched_state_t;

endpackage

// File: rtl/mac_frame_buf.sv
// mac_frame_buf: DEPTH x DATA_W simple dual-port frame buffer.
//   clk, reset           : clock; reset clears only the read data register
//   wr_en/wr_addr/wr_data: write port
//   rd_en/rd_addr        : read request; rd_data is valid one cycle later
// The read register holds its value when rd_en is low.
module mac_frame_buf
    import mac_sched_pkg::*;
#(
    parameter int DEPTH = RS_CNT_STD,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/mac_frame_sched.sv
// mac_frame_sched: normalises each input frame to RS_CNT words (pad/truncate),
// buffers it, releases it as one gap-free burst and then waits for all lanes
// of the downstream splitter to report tlast before taking the next frame.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   s_axis_input_*            : upstream frame stream (tvalid/tready/tdata/tlast)
//   m_axis_output_*           : burst to the splitter (tvalid/tready/tdata/tlast)
//   lane_tlast[LANE_CNT]      : per-lane tlast pulses from the splitter
//   busy                      : high whenever the scheduler is not in FILL
//   err_timeout               : sticky DRAIN timeout flag
//   frame_cnt/pad_cnt/trunc_cnt : 16-bit wrapping statistics
// Build option: define MAC_SCHED_STATS_EN to build the statistics counters;
// otherwise the three statistics outputs are tied to zero.
module mac_frame_sched
    import mac_sched_pkg::*;
#(
    parameter int          RS_CNT        = RS_CNT_STD,
    parameter logic [63:0] PAD_WORD      = 64'h0,
    parameter int          DRAIN_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_axis_input_tvalid,
    output logic                s_axis_input_tready,
    input  logic [DATA_W-1:0]   s_axis_input_tdata,
    input  logic                s_axis_input_tlast,
    output logic                m_axis_output_tvalid,
    input  logic                m_axis_output_tready,
    output logic [DATA_W-1:0]   m_axis_output_tdata,
    output logic                m_axis_output_tlast,
    input  logic [LANE_CNT-1:0] lane_tlast,
    output logic                busy,
    output logic                err_timeout,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         pad_cnt,
    output logic [15:0]         trunc_cnt
);

    localparam int AW = (RS_CNT > 1) ? $clog2(RS_CNT) : 1;
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(RS_CNT - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(DRAIN_TIMEOUT - 1);

    sched_state_t        state_reg, state_next;
    logic [AW-1:0]       wr_cnt_reg, wr_cnt_next;
    logic [AW-1:0]       rd_cnt_reg, rd_cnt_next;
    logic [TW-1:0]       drain_cnt_reg, drain_cnt_next;
    logic [LANE_CNT-1:0] lane_done_reg, lane_done_next;
    logic                err_reg, err_next;
    logic                m_tvalid_reg, m_tlast_reg;

    logic                s_hs;
    logic [LANE_CNT-1:0] lane_seen;
    logic                buf_wr_en;
    logic [DATA_W-1:0]   buf_wr_data;
    logic                buf_rd_en;

    assign s_axis_input_tready = (state_reg == FILL) || (state_reg == DROP);
    assign s_hs      = s_axis_input_tvalid && s_axis_input_tready;
    // A pulse arriving in the same cycle the last missing bit is needed counts immediately.
    assign lane_seen = lane_done_reg | lane_tlast;
    assign busy      = (state_reg != FILL);

    always_comb begin
        state_next     = state_reg;
        wr_cnt_next    = wr_cnt_reg;
        rd_cnt_next    = rd_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        lane_done_next = lane_done_reg;
        err_next       = err_reg;
        buf_wr_en      = 1'b0;
        buf_wr_data    = s_axis_input_tdata;
        buf_rd_en      = 1'b0;
        case (state_reg)
            FILL: begin
                if (s_hs) begin
                    buf_wr_en = 1'b1;
                    if (wr_cnt_reg == LAST_IDX) begin
                        state_next = s_axis_input_tlast ? READY : DROP;
                    end else begin
                        wr_cnt_next = wr_cnt_reg + 1'b1;
                        if (s_axis_input_tlast) begin
                            state_next = PAD;
                        end
                    end
                end
            end
            DROP: begin
                if (s_hs && s_axis_input_tlast) begin
                    state_next = READY;
                end
            end
            PAD: begin
                buf_wr_en   = 1'b1;
                buf_wr_data = PAD_WORD;
                if (wr_cnt_reg == LAST_IDX) begin
                    state_next = READY;
                end else begin
                    wr_cnt_next = wr_cnt_reg + 1'b1;
                end
            end
            READY: begin
                if (m_axis_output_tready) begin
                    state_next  = SEND;
                    rd_cnt_next = '0;
                end
            end
            SEND: begin
                // Burst is committed: m_tready is deliberately not looked at here.
                buf_rd_en      = 1'b1;
                lane_done_next = lane_seen;
                if (rd_cnt_reg == LAST_IDX) begin
                    state_next     = DRAIN;
                    rd_cnt_next    = '0;
                    drain_cnt_next = '0;
                end else begin
                    rd_cnt_next = rd_cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (lane_seen == '1) begin
                    state_next     = FILL;
                    lane_done_next = '0;
                    wr_cnt_next    = '0;
                end else if (drain_cnt_reg == TO_LAST) begin
                    state_next     = FILL;
                    lane_done_next = '0;
                    wr_cnt_next    = '0;
                    err_next       = 1'b1;
                end else begin
                    lane_done_next = lane_seen;
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= FILL;
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            drain_cnt_reg <= '0;
            lane_done_reg <= '0;
            err_reg       <= 1'b0;
            m_tvalid_reg  <= 1'b0;
            m_tlast_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            lane_done_reg <= lane_done_next;
            err_reg       <= err_next;
            // Output flags are aligned with the registered buffer read.
            m_tvalid_reg  <= (state_reg == SEND);
            m_tlast_reg   <= (state_reg == SEND) && (rd_cnt_reg == LAST_IDX);
        end
    end

    mac_frame_buf #(
        .DEPTH (RS_CNT),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_cnt_reg),
        .wr_data (buf_wr_data),
        .rd_en   (buf_rd_en),
        .rd_addr (rd_cnt_reg),
        .rd_data (m_axis_output_tdata)
    );

    assign m_axis_output_tvalid = m_tvalid_reg;
    assign m_axis_output_tlast  = m_tlast_reg;
    assign err_timeout          = err_reg;

`ifdef MAC_SCHED_STATS_EN
    logic [15:0] frame_cnt_reg, pad_cnt_reg, trunc_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg <= '0;
            pad_cnt_reg   <= '0;
            trunc_cnt_reg <= '0;
        end else begin
            if (state_reg == DRAIN && lane_seen == '1) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (state_reg == PAD && wr_cnt_reg == LAST_IDX) begin
                pad_cnt_reg <= pad_cnt_reg + 16'd1;
            end
            if (state_reg == DROP && s_hs && s_axis_input_tlast) begin
                trunc_cnt_reg <= trunc_cnt_reg + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_reg;
    assign pad_cnt   = pad_cnt_reg;
    assign trunc_cnt = trunc_cnt_reg;
`else
    assign frame_cnt = '0;
    assign pad_cnt   = '0;
    assign trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_frame_sched.sv
// tb_mac_frame_sched: randomized self-checking bench for mac_frame_sched.
// Expected bursts come from a frame-level model: every accepted input frame is
// cut/padded to RS words and queued; each DUT output beat is compared with it.
module tb_mac_frame_sched;

    localparam int RS = 236;
    localparam int TO = 64;
    localparam logic [63:0] PADW = 64'h0;
`ifdef MAC_SCHED_STATS_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic        clk;
    logic        reset;
    logic        s_tvalid, s_tready, s_tlast;
    logic [63:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  lane_tlast;
    logic        busy, err_timeout;
    logic [15:0] frame_cnt, pad_cnt, trunc_cnt;

    mac_frame_sched #(
        .RS_CNT        (RS),
        .PAD_WORD      (PADW),
        .DRAIN_TIMEOUT (TO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .s_axis_input_tvalid  (s_tvalid),
        .s_axis_input_tready  (s_tready),
        .s_axis_input_tdata   (s_tdata),
        .s_axis_input_tlast   (s_tlast),
        .m_axis_output_tvalid (m_tvalid),
        .m_axis_output_tready (m_tready),
        .m_axis_output_tdata  (m_tdata),
        .m_axis_output_tlast  (m_tlast),
        .lane_tlast           (lane_tlast),
        .busy                 (busy),
        .err_timeout          (err_timeout),
        .frame_cnt            (frame_cnt),
        .pad_cnt              (pad_cnt),
        .trunc_cnt            (trunc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    logic [63:0] exp_words[$];
    longint      exp_start_q[$];
    logic [63:0] cur_frame[$];
    int          cur_len  = 0;
    int          beat_idx = 0;
    int          exp_frame = 0, exp_pad = 0, exp_trunc = 0;
    logic        exp_err = 1'b0;
    logic [7:0]  lane_mask = 8'h00;
    logic        lane_busy = 1'b0;
    longint      tl_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Input monitor, frame model and per-beat output compare.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (s_tvalid && s_tready) begin
                if (cur_len < RS) cur_frame.push_back(s_tdata);
                cur_len++;
                if (s_tlast) begin
                    while (cur_frame.size() < RS) cur_frame.push_back(PADW);
                    foreach (cur_frame[k]) exp_words.push_back(cur_frame[k]);
                    if (cur_len < RS) exp_pad++;
                    else if (cur_len > RS) exp_trunc++;
                    // tlast accepted at edge cyc+1; padding adds one cycle per missing word
                    exp_start_q.push_back(m_tready ?
                        cyc + 1 + ((cur_len < RS) ? (RS - cur_len) : 0) + 2 : -1);
                    $display("frame in: len=%0d expected_start=%0d", cur_len, exp_start_q[$]);
                    cur_frame.delete();
                    cur_len = 0;
                end
            end
            if (m_tvalid) begin
                if (exp_words.size() == 0) begin
                    check("unexpected_beat", m_tvalid, 1'b0);
                end else begin
                    if (beat_idx == 0) begin
                        longint st;
                        st = (exp_start_q.size() != 0) ? exp_start_q.pop_front() : -1;
                        if (st >= 0) check("burst_latency", cyc, st);
                    end
                    check("beat_data", m_tdata, exp_words.pop_front());
                    check("beat_tlast", m_tlast, beat_idx == RS - 1);
                    if (m_tlast) begin
                        tl_cyc = cyc;
                        $display("burst out: %0d beats ending cycle %0d", beat_idx + 1, cyc);
                    end
                    beat_idx = (beat_idx == RS - 1) ? 0 : beat_idx + 1;
                end
            end else if (beat_idx != 0) begin
                check("burst_gap", m_tvalid, 1'b1);
                for (int k = beat_idx; k < RS; k++) void'(exp_words.pop_front());
                beat_idx = 0;
            end
        end
    end

    // Splitter lane model: after each burst, every unmasked lane pulses tlast once.
    initial begin
        lane_tlast = '0;
        forever begin
            @(negedge clk);
            if (!reset && m_tvalid && m_tlast) begin
                logic [7:0] rem, pick;
                lane_busy = 1'b1;
                rem = 8'hFF & ~lane_mask;
                for (int k = 0; k < 12 && rem != 0; k++) begin
                    @(posedge clk); #1;
                    pick = (k == 11) ? rem : (rem & 8'($urandom));
                    lane_tlast = pick;
                    rem = rem & ~pick;
                end
                @(posedge clk); #1;
                lane_tlast = '0;
                if (lane_mask == 0) exp_frame++;
                lane_busy = 1'b0;
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send_frame(input int len, input int gap_pct, output int stalls);
        logic acc;
        int   guard;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = {$urandom, $urandom};
            s_tlast  = (i == len - 1);
            guard = 0;
            do begin
                @(negedge clk);
                acc = s_tready;
                if (!acc) stalls++;
                guard++;
                @(posedge clk); #1;
            end while (!acc && guard < 5000);
            if (!acc) begin
                check("s_tready_wait", s_tready, 1'b1);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge clk);
        check("s_tready_after_tlast", s_tready, 1'b0);
        check("busy_after_tlast", busy, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy || lane_busy || exp_words.size() != 0) && g < 3000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_s_tready"}, s_tready, 1'b1);
        check({tag, "_pending_beats"}, exp_words.size(), 0);
        check({tag, "_err_timeout"}, err_timeout, exp_err);
        check({tag, "_frame_cnt"}, frame_cnt, 16'(exp_frame * S));
        check({tag, "_pad_cnt"}, pad_cnt, 16'(exp_pad * S));
        check({tag, "_trunc_cnt"}, trunc_cnt, 16'(exp_trunc * S));
        $display("%s: idle at cycle %0d, frames=%0d pads=%0d truncs=%0d", tag, cyc, frame_cnt, pad_cnt, trunc_cnt);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_m_tvalid"}, m_tvalid, 1'b0);
        check({tag, "_m_tlast"}, m_tlast, 1'b0);
        check({tag, "_s_tready"}, s_tready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err_timeout, 1'b0);
        check({tag, "_frame_cnt"}, frame_cnt, 16'h0);
        check({tag, "_pad_cnt"}, pad_cnt, 16'h0);
        check({tag, "_trunc_cnt"}, trunc_cnt, 16'h0);
    endtask

    initial begin
        int st, g, hi_seen, len;
        reset = 1'b1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        check("reset_m_tdata", m_tdata, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // exact-length frame
        send_frame(RS, 0, st);
        wait_idle("exact");
        check("exact_frame_cnt_pin", frame_cnt, 16'(S));

        // short frame is padded
        send_frame(100, 0, st);
        wait_idle("pad");
        check("pad_cnt_pin", pad_cnt, 16'(S));

        // long frame truncated, tail consumed without back-pressure, then a short one
        send_frame(300, 0, st);
        check("drop_no_stall", st, 0);
        send_frame(10, 0, st);
        wait_idle("trunc");
        check("trunc_cnt_pin", trunc_cnt, 16'(S));
        check("pad_cnt_pin2", pad_cnt, 16'(2 * S));

        // downstream not ready for 20 cycles in READY, then drops mid-burst
        m_tready = 1'b0;
        send_frame(RS, 0, st);
        hi_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_tvalid) hi_seen++;
        end
        check("ready_hold_tvalid", hi_seen, 0);
        @(posedge clk); #1;
        m_tready = 1'b1;
        if (exp_start_q.size() == 1) exp_start_q[0] = cyc + 2;
        g = 0;
        while (beat_idx < 100 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("midburst_reached", beat_idx >= 100, 1'b1);
        @(posedge clk); #1;
        m_tready = 1'b0;
        repeat (30) @(posedge clk);
        #1 m_tready = 1'b1;
        wait_idle("tready");

        // lane 5 withheld: DRAIN times out after TO cycles
        lane_mask = 8'h20;
        tl_cyc = -1;
        send_frame(20, 0, st);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!err_timeout && g < 1000);
        check("timeout_latency", cyc - tl_cyc, 64'(TO));
        exp_err = 1'b1;
        wait_idle("timeout");
        lane_mask = 8'h00;
        send_frame(5, 0, st);
        wait_idle("after_timeout");

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 300);
            send_frame(len, 20, st);
            wait_idle("random");
        end

        // reset at burst beat 50
        send_frame(RS, 0, st);
        g = 0;
        while (beat_idx < 50 && g < 500) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_words.delete(); exp_start_q.delete(); cur_frame.delete();
        cur_len = 0; beat_idx = 0;
        exp_frame = 0; exp_pad = 0; exp_trunc = 0; exp_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        send_frame(30, 0, st);
        wait_idle("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
